// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- decode-stage hazard unit.
//
// Detects load-use hazards that bypassing cannot cover and sequences the
// multiply/divide unit (start strobe, wait with stall, forced release on
// timeout). Its stall output is the same stall seen by bypass_ctrl.
//
// Ports:
//   clock         rising-edge clock
//   reset         asynchronous active-low reset
//   ir_fd         instruction in the F/D latch
//   ir_dx         instruction in the D/X latch
//   dx_type       D/X instruction type: 00 R, 01 I, 10 JI, 11 JII
//   branch_taken  taken branch/jump resolved in X this cycle
//   md_ready      multdiv result valid
//   stall         hold PC, F/D and D/X
//   bubble_xm     load nop into X/M on next edge
//   flush_fd      load nop into F/D on next edge
//   flush_dx      load nop into D/X on next edge
//   md_start      one-cycle multdiv operand capture strobe
//   md_timeout    sticky flag: multdiv exceeded MD_MAX_CYCLES
//   stall_cycles  (HAZARD_PERF_EN only) saturating count of stalled cycles
//
// Optional feature macro: HAZARD_PERF_EN.

module hazard_ctrl #(
  parameter int MD_MAX_CYCLES = 40,
  parameter int CNT_W         = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir_fd,
  input  logic [31:0] ir_dx,
  input  logic [1:0]  dx_type,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        stall,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        flush_dx,
  output logic        md_start,
`ifdef HAZARD_PERF_EN
  output logic [15:0] stall_cycles,
`endif
  output logic        md_timeout
);

  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] ALU_MUL  = 5'b00110;
  localparam logic [4:0] ALU_DIV  = 5'b00111;

  localparam logic [CNT_W-1:0] MD_LAST = CNT_W'(MD_MAX_CYCLES - 1);

  typedef enum logic {RUN, MD_WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_set;

  // Source-1 field is read by R-type and the I-type group.
  function automatic logic reads_src1(input logic [4:0] op);
    return (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_SW) ||
           (op == OP_LW) || (op == OP_BNE) || (op == OP_BLT);
  endfunction

  // These opcodes read their rd field as the second source.
  function automatic logic src2_is_rd(input logic [4:0] op);
    return (op == OP_SW) || (op == OP_BNE) || (op == OP_BLT) || (op == OP_JR);
  endfunction

  logic [4:0] fd_op, fd_src1, fd_src2, dx_op, dx_rd;
  logic       fd_use1, fd_use2, fd_live, dx_lw, dx_md, load_use;

  assign fd_op   = ir_fd[31:27];
  assign fd_src1 = ir_fd[21:17];
  assign fd_src2 = src2_is_rd(fd_op) ? ir_fd[26:22] : ir_fd[16:12];
  assign fd_live = (ir_fd != 32'd0);
  assign fd_use1 = reads_src1(fd_op);
  // A store's data register (its rd field) is served by the D-stage bypass,
  // so only its base register can cause a load-use stall.
  assign fd_use2 = (src2_is_rd(fd_op) && (fd_op != OP_SW)) || (fd_op == OP_RTYPE);

  assign dx_op = ir_dx[31:27];
  assign dx_rd = ir_dx[26:22];
  assign dx_lw = (dx_op == OP_LW);
  assign dx_md = (dx_op == OP_RTYPE) && (dx_type == 2'b00) &&
                 ((ir_dx[6:2] == ALU_MUL) || (ir_dx[6:2] == ALU_DIV));

  assign load_use = dx_lw && (dx_rd != 5'd0) && fd_live &&
                    ((fd_use1 && (fd_src1 == dx_rd)) ||
                     (fd_use2 && (fd_src2 == dx_rd)));

  logic unused_dx_bits;
  assign unused_dx_bits = ^{ir_dx[21:7], ir_dx[1:0]};

  always_comb begin
    stall       = 1'b0;
    bubble_xm   = 1'b0;
    flush_fd    = 1'b0;
    flush_dx    = 1'b0;
    md_start    = 1'b0;
    timeout_set = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    // Outputs are forced low while reset is asserted, independent of inputs.
    if (reset) begin
      case (state_q)
        RUN: begin
          if (branch_taken) begin
            flush_fd = 1'b1;
            flush_dx = 1'b1;
          end else if (load_use) begin
            stall    = 1'b1;
            flush_dx = 1'b1;
          end else if (dx_md) begin
            md_start = 1'b1;
            state_d  = MD_WAIT;
            cnt_d    = '0;
          end
        end
        MD_WAIT: begin
          cnt_d = cnt_q + 1'b1;
          if (md_ready) begin
            state_d = RUN;
          end else if (cnt_q == MD_LAST) begin
            // Release in this cycle so the hung op leaves D/X and is not
            // restarted when the FSM returns to RUN.
            timeout_set = 1'b1;
            state_d     = RUN;
          end else begin
            stall     = 1'b1;
            bubble_xm = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      md_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (timeout_set) md_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 16'd0;
    end else if (stall && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl -- directed-vector bench for hazard_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 1 time unit later, well away from the next edge.

module tb_hazard_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ir_fd, ir_dx;
  logic [1:0]  dx_type;
  logic        branch_taken, md_ready;
  logic        stall, bubble_xm, flush_fd, flush_dx, md_start, md_timeout;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clock = ~clock;

  hazard_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .ir_fd        (ir_fd),
    .ir_dx        (ir_dx),
    .dx_type      (dx_type),
    .branch_taken (branch_taken),
    .md_ready     (md_ready),
    .stall        (stall),
    .bubble_xm    (bubble_xm),
    .flush_fd     (flush_fd),
    .flush_dx     (flush_dx),
    .md_start     (md_start),
`ifdef HAZARD_PERF_EN
    .stall_cycles (stall_cycles),
`endif
    .md_timeout   (md_timeout)
  );

  function automatic logic [31:0] r_op(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [4:0] alu);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction

  function automatic logic [31:0] i_op(input logic [4:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic chk_out(input string tag, input logic s, input logic b,
                         input logic ffd, input logic fdx, input logic ms);
    check({tag, ".stall"},     {31'd0, stall},     {31'd0, s});
    check({tag, ".bubble_xm"}, {31'd0, bubble_xm}, {31'd0, b});
    check({tag, ".flush_fd"},  {31'd0, flush_fd},  {31'd0, ffd});
    check({tag, ".flush_dx"},  {31'd0, flush_dx},  {31'd0, fdx});
    check({tag, ".md_start"},  {31'd0, md_start},  {31'd0, ms});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input logic [31:0] fd, input logic [31:0] dx, input logic [1:0] ty,
                       input logic br, input logic rdy);
    ir_fd = fd; ir_dx = dx; dx_type = ty; branch_taken = br; md_ready = rdy;
    #1;
  endtask

  logic [31:0] lw5, lw7, add_dep, mul3, div4;

  initial begin
    lw5     = i_op(5'b01000, 5'd5, 5'd1, 17'd0);
    lw7     = i_op(5'b01000, 5'd7, 5'd1, 17'd0);
    add_dep = r_op(5'd6, 5'd5, 5'd2, 5'd0);
    mul3    = r_op(5'd3, 5'd1, 5'd2, 5'b00110);
    div4    = r_op(5'd4, 5'd1, 5'd2, 5'b00111);

    reset = 1'b0;
    ir_fd = '0; ir_dx = '0; dx_type = 2'b00; branch_taken = 1'b0; md_ready = 1'b0;
    #2;
    chk_out("reset", 0, 0, 0, 0, 0);
    check("reset.md_timeout", {31'd0, md_timeout}, 32'd0);
    tick();
    reset = 1'b1;

    // Test 1: load-use through src1, then through src2
    apply(add_dep, lw5, 2'b01, 0, 0);
    chk_out("t1_lu", 1, 0, 0, 1, 0);
    tick();
    apply(add_dep, 32'd0, 2'b00, 0, 0);
    chk_out("t1_after", 0, 0, 0, 0, 0);
    tick();
    apply(r_op(5'd6, 5'd2, 5'd5, 5'd0), lw5, 2'b01, 0, 0);
    chk_out("t1_src2", 1, 0, 0, 1, 0);
    tick();

    // Test 2: store data register does not stall, base register does
    apply(i_op(5'b00111, 5'd5, 5'd7, 17'd0), lw5, 2'b01, 0, 0);
    chk_out("t2_sw_data", 0, 0, 0, 0, 0);
    tick();
    apply(i_op(5'b00111, 5'd5, 5'd7, 17'd0), lw7, 2'b01, 0, 0);
    chk_out("t2_sw_base", 1, 0, 0, 1, 0);
    tick();

    // Test 3: mul start, 17 wait cycles, release on md_ready
    apply(32'd0, mul3, 2'b00, 0, 0);
    chk_out("t3_start", 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 17; i++) begin
      apply(32'd0, mul3, 2'b00, 0, 0);
      chk_out($sformatf("t3_wait%0d", i), 1, 1, 0, 0, 0);
      tick();
    end
    apply(32'd0, mul3, 2'b00, 0, 1);
    chk_out("t3_ready", 0, 0, 0, 0, 0);
    tick();
    apply(32'd0, 32'd0, 2'b00, 0, 1);
    chk_out("t3_run_ignores_ready", 0, 0, 0, 0, 0);
    tick();
    apply(32'd0, mul3, 2'b01, 0, 0);
    chk_out("t3_type_gate", 0, 0, 0, 0, 0);
    tick();

    // Test 4: branch_taken beats load-use and md_start
    apply(add_dep, lw5, 2'b01, 1, 0);
    chk_out("t4_br_lu", 0, 0, 1, 1, 0);
    tick();
    apply(32'd0, mul3, 2'b00, 1, 0);
    chk_out("t4_br_md", 0, 0, 1, 1, 0);
    tick();
    apply(32'd0, 32'd0, 2'b00, 0, 0);
    chk_out("t4_still_run", 0, 0, 0, 0, 0);
    tick();
`ifdef HAZARD_PERF_EN
    check("perf_t1_t4", {16'd0, stall_cycles}, 32'd20);
`endif

    // Test 5: div timeout after 40 wait cycles
    apply(32'd0, div4, 2'b00, 0, 0);
    chk_out("t5_start", 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 39; i++) begin
      apply(32'd0, div4, 2'b00, 0, 0);
      chk_out($sformatf("t5_wait%0d", i), 1, 1, 0, 0, 0);
      tick();
    end
    apply(32'd0, div4, 2'b00, 0, 0);
    chk_out("t5_release", 0, 0, 0, 0, 0);
    check("t5_to_pre", {31'd0, md_timeout}, 32'd0);
    tick();
    apply(32'd0, 32'd0, 2'b00, 0, 0);
    check("t5_to_set", {31'd0, md_timeout}, 32'd1);
    chk_out("t5_run", 0, 0, 0, 0, 0);
    tick();
    check("t5_to_held", {31'd0, md_timeout}, 32'd1);
`ifdef HAZARD_PERF_EN
    check("perf_t1_t5", {16'd0, stall_cycles}, 32'd59);
`endif

    // Second div run, reset asserted in the middle of MD_WAIT
    apply(32'd0, div4, 2'b00, 0, 0);
    chk_out("t5b_start", 0, 0, 0, 0, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      apply(32'd0, div4, 2'b00, 0, 0);
      chk_out($sformatf("t5b_wait%0d", i), 1, 1, 0, 0, 0);
      tick();
    end
    check("t5b_to_sticky", {31'd0, md_timeout}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("t5b_async_rst", 0, 0, 0, 0, 0);
    check("t5b_rst_timeout", {31'd0, md_timeout}, 32'd0);
`ifdef HAZARD_PERF_EN
    check("perf_rst", {16'd0, stall_cycles}, 32'd0);
`endif
    apply(32'd0, 32'd0, 2'b00, 0, 0);
    tick();
    reset = 1'b1;
    #1;
    chk_out("t5b_run_after_rst", 0, 0, 0, 0, 0);
    tick();

    // Test 6: register 0 and nop words never hazard
    apply(r_op(5'd6, 5'd0, 5'd0, 5'd0), i_op(5'b01000, 5'd0, 5'd1, 17'd0), 2'b01, 0, 0);
    chk_out("t6_lw_r0", 0, 0, 0, 0, 0);
    tick();
    apply(32'd0, 32'd0, 2'b00, 0, 0);
    chk_out("t6_nop_nop", 0, 0, 0, 0, 0);
    tick();
    apply(32'd0, lw5, 2'b01, 0, 0);
    chk_out("t6_lw_fd_nop", 0, 0, 0, 0, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
